// File: rtl/cga_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cga_vram_arbiter
// Description : Shares the single CGA/Tandy VRAM port between the display
//               fetch slots of the sequencer and ISA CPU memory cycles in the
//               B8000-BFFFF window. Display fetch always owns the port when it
//               asks for it; the CPU is serviced inside sequencer ISA windows
//               (or after a starvation timeout) and held off with bus_rdy.
// Revision    : 1.0 - initial release
// ============================================================================
module cga_vram_arbiter #(
    parameter logic [19:0] FRAMEBUFFER_ADDR = 20'hB8000,
    parameter int unsigned USE_BUS_WAIT     = 1,
    parameter int unsigned ACCESS_CYCLES    = 2,
    parameter logic [5:0]  MAX_WAIT         = 6'd40
) (
    // clock / reset
    input  logic        clk,
    input  logic        reset_l,

    // ISA bus side
    input  logic [19:0] bus_a,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic        bus_aen,
    input  logic [7:0]  bus_d,
    output logic        bus_rdy,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rd_active,
    input  logic        tandy_32k,

    // sequencer side
    input  logic        disp_req,
    input  logic [18:0] disp_addr,
    input  logic        isa_op_enable,

    // VRAM port
    output logic [18:0] ram_a,
    output logic        ram_we_l,
    output logic [7:0]  ram_wd,
    input  logic [7:0]  ram_d
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Access counter is 3 bits wide, enough for 1..7 port-owning clocks.
    localparam logic [2:0] ACC_LAST    = 3'(ACCESS_CYCLES - 1);
    localparam logic [4:0] WINDOW_BITS = FRAMEBUFFER_ADDR[19:15];
    localparam logic [5:0] WAIT_SAT    = 6'h3F;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_ACCESS    = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_wait_cnt;
    logic [2:0]  r_acc_cnt;
    logic        r_is_write;
    logic [18:0] r_cpu_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic        r_bus_rdy;

    // Strobe synchronizers: [0] metastability stage, [1] usable stage.
    logic [1:0]  r_memr_sync;
    logic [1:0]  r_memw_sync;
    logic        r_memr_prev;
    logic        r_memw_prev;

    logic        w_hit;
    logic        w_memr_fall;
    logic        w_memw_fall;
    logic        w_req;
    logic [18:0] w_cpu_addr;
    logic        w_slot_go;
    logic        w_strobe_high;
    logic        w_cpu_drive;

    // ------------------------------------------------------------------------
    // Strobe synchronization and edge detection
    // ------------------------------------------------------------------------
    // Two-flop synchronizers plus a history flop for falling-edge detection;
    // all reset high so that no phantom edge appears after reset.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_memr_sync <= 2'b11;
            r_memw_sync <= 2'b11;
            r_memr_prev <= 1'b1;
            r_memw_prev <= 1'b1;
        end else begin
            r_memr_sync <= {r_memr_sync[0], bus_memr_l};
            r_memw_sync <= {r_memw_sync[0], bus_memw_l};
            r_memr_prev <= r_memr_sync[1];
            r_memw_prev <= r_memw_sync[1];
        end
    end

    assign w_memr_fall = r_memr_prev & ~r_memr_sync[1];
    assign w_memw_fall = r_memw_prev & ~r_memw_sync[1];

    // Address decode: 32K-aligned window, suppressed during DMA cycles.
    assign w_hit = (bus_a[19:15] == WINDOW_BITS) & ~bus_aen;

    // A write edge and a read edge arriving together resolve as a write.
    assign w_req = w_hit & (w_memw_fall | w_memr_fall);

    // Tandy 32K mode uses a[14]; CGA 16K mode mirrors the upper half.
    assign w_cpu_addr = {4'h0, tandy_32k & bus_a[14], bus_a[13:0]};

    // Read direction for the external data-bus transceiver; follows the raw
    // strobe so it is valid for the whole ISA read cycle.
    assign cpu_rd_active = ~bus_memr_l & w_hit;

    // ------------------------------------------------------------------------
    // Arbitration control
    // ------------------------------------------------------------------------
    // The wait counter saturates above MAX_WAIT, so the starvation guard
    // compares with >= to stay armed while display fetch keeps the port busy.
    assign w_slot_go = ~disp_req & (isa_op_enable | (r_wait_cnt >= MAX_WAIT));

    // The CPU is done only once the strobe of its own direction has gone high.
    assign w_strobe_high = r_is_write ? r_memw_sync[1] : r_memr_sync[1];

    // CPU request FSM; owns the latched transaction and the registered outputs.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 6'd0;
            r_acc_cnt  <= 3'd0;
            r_is_write <= 1'b0;
            r_cpu_addr <= 19'd0;
            r_wdata    <= 8'h00;
            r_rdata    <= 8'h00;
            r_bus_rdy  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // New edges are only honoured here; edges seen in any
                    // other state are consumed by the history flops.
                    if (w_req) begin
                        r_state    <= ST_WAIT_SLOT;
                        r_wait_cnt <= 6'd0;
                        r_acc_cnt  <= 3'd0;
                        r_is_write <= w_memw_fall;
                        r_cpu_addr <= w_cpu_addr;
                        r_wdata    <= bus_d;
                        r_bus_rdy  <= 1'b0;
                    end
                end

                ST_WAIT_SLOT: begin
                    if (w_slot_go) begin
                        r_state   <= ST_ACCESS;
                        r_acc_cnt <= 3'd0;
                    end else if (r_wait_cnt != WAIT_SAT) begin
                        r_wait_cnt <= r_wait_cnt + 6'd1;
                    end
                end

                ST_ACCESS: begin
                    if (disp_req) begin
                        // Display fetch pre-empts; retry from scratch in a
                        // later window, keeping the accumulated wait time.
                        r_state   <= ST_WAIT_SLOT;
                        r_acc_cnt <= 3'd0;
                    end else if (r_acc_cnt == ACC_LAST) begin
                        r_state   <= ST_DONE;
                        r_bus_rdy <= 1'b1;
                        if (!r_is_write) begin
                            r_rdata <= ram_d;
                        end
                    end else begin
                        r_acc_cnt <= r_acc_cnt + 3'd1;
                    end
                end

                ST_DONE: begin
                    if (w_strobe_high) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // VRAM port multiplexer
    // ------------------------------------------------------------------------
    // Combinational so that a display request mid-access releases the write
    // enable in the very cycle it appears.
    assign w_cpu_drive = (r_state == ST_ACCESS) & ~disp_req;
    assign ram_a       = w_cpu_drive ? r_cpu_addr : disp_addr;
    assign ram_we_l    = ~(w_cpu_drive & r_is_write);
    assign ram_wd      = r_wdata;
    assign cpu_rdata   = r_rdata;

    // ------------------------------------------------------------------------
    // ISA ready
    // ------------------------------------------------------------------------
    generate
        if (USE_BUS_WAIT != 0) begin : g_rdy_wait
            assign bus_rdy = r_bus_rdy;
        end else begin : g_rdy_tied
            assign bus_rdy = 1'b1;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cga_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cga_vram_arbiter
// Description : Self-checking bench for cga_vram_arbiter. A byte-array VRAM
//               model sits on the RAM port; a transaction-level memory image
//               predicts every CPU read and write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cga_vram_arbiter;

    localparam int ACC  = 2;
    localparam int MAXW = 40;

    logic        clk = 1'b0;
    logic        reset_l;
    logic [19:0] bus_a;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic        bus_aen;
    logic [7:0]  bus_d;
    logic        bus_rdy;
    logic [7:0]  cpu_rdata;
    logic        cpu_rd_active;
    logic        tandy_32k;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic        isa_op_enable;
    logic [18:0] ram_a;
    logic        ram_we_l;
    logic [7:0]  ram_wd;
    logic [7:0]  ram_d;

    // VRAM model: bytes written through the port, else a fixed seed pattern.
    logic [7:0]  vram     [0:32767];
    bit          vram_wr  [0:32767];
    // Expected memory image, updated per completed CPU transaction.
    logic [7:0]  exp_mem  [0:32767];

    int          checks = 0;
    int          errors = 0;
    int          completed = 0;
    int          partial = 0;
    int          run = 0;
    logic [18:0] cur_wa, last_wa;
    logic [7:0]  cur_wd, last_wd;
    logic [7:0]  last_rd_exp = 8'h00;
    bit          win_mode = 1'b0;
    bit          disp_en = 1'b0;
    bit          disp_manual = 1'b0;
    int          cyc = 0;

    always #5 clk = ~clk;

    cga_vram_arbiter dut (
        .clk           (clk),
        .reset_l       (reset_l),
        .bus_a         (bus_a),
        .bus_memr_l    (bus_memr_l),
        .bus_memw_l    (bus_memw_l),
        .bus_aen       (bus_aen),
        .bus_d         (bus_d),
        .bus_rdy       (bus_rdy),
        .cpu_rdata     (cpu_rdata),
        .cpu_rd_active (cpu_rd_active),
        .tandy_32k     (tandy_32k),
        .disp_req      (disp_req),
        .disp_addr     (disp_addr),
        .isa_op_enable (isa_op_enable),
        .ram_a         (ram_a),
        .ram_we_l      (ram_we_l),
        .ram_wd        (ram_wd),
        .ram_d         (ram_d)
    );

    function automatic logic [7:0] seed_byte(input logic [14:0] i);
        return (i[7:0] * 8'd37) ^ {1'b0, i[14:8]} ^ 8'h5C;
    endfunction

    function automatic logic [14:0] map_addr(input logic [19:0] a, input bit t);
        return t ? a[14:0] : {1'b0, a[13:0]};
    endfunction

    assign ram_d = vram_wr[ram_a[14:0]] ? vram[ram_a[14:0]] : seed_byte(ram_a[14:0]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM model and write-burst monitor; samples pre-edge port values.
    always @(posedge clk) begin
        if (reset_l === 1'b1 && disp_req === 1'b1) begin
            chk("disp_prio_we", 32'(ram_we_l), 32'd1);
            chk("disp_prio_addr", 32'(ram_a), 32'(disp_addr));
        end
        if (ram_we_l === 1'b0) begin
            vram[ram_a[14:0]]    <= ram_wd;
            vram_wr[ram_a[14:0]] <= 1'b1;
            run++;
            cur_wa = ram_a;
            cur_wd = ram_wd;
        end else if (run != 0) begin
            if (run == ACC) begin
                completed++;
                last_wa = cur_wa;
                last_wd = cur_wd;
            end else begin
                partial++;
            end
            run = 0;
        end
    end

    // Sequencer model: ISA window pulses and optional random display fetch.
    always @(negedge clk) begin
        cyc++;
        isa_op_enable = win_mode && (cyc % 8 == 0);
        if (!disp_manual) begin
            disp_req  = disp_en && ($urandom_range(0, 3) == 0);
            disp_addr = 19'($urandom);
        end
    end

    task automatic wait_level(input logic lvl, input int limit, output int n);
        n = 0;
        while (bus_rdy !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_we_low(input int limit, output int n);
        n = 0;
        while (ram_we_l !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One complete ISA memory cycle with full checking.
    task automatic cpu_access(input bit wr, input logic [19:0] a, input logic [7:0] d, input bit t);
        int          n;
        int          exp_done;
        logic [14:0] ma;
        ma       = map_addr(a, t);
        exp_done = completed + (wr ? 1 : 0);
        bus_a = a; bus_d = d; tandy_32k = t; bus_aen = 1'b0;
        @(negedge clk); #1;
        if (wr) bus_memw_l = 1'b0; else bus_memr_l = 1'b0;
        wait_level(1'b0, 6, n);
        chk("rdy_fall_latency", 32'(n <= 3), 32'd1);
        chk("rd_active", 32'(cpu_rd_active), 32'(!wr));
        wait_level(1'b1, 400, n);
        chk("rdy_rise_before_release", 32'(n < 400), 32'd1);
        bus_memw_l = 1'b1;
        bus_memr_l = 1'b1;
        repeat (6) @(negedge clk);
        chk("write_count", 32'(completed), 32'(exp_done));
        if (wr) begin
            exp_mem[ma] = d;
            chk("write_addr", 32'(last_wa), {17'd0, ma});
            chk("write_data", 32'(last_wd), 32'(d));
        end else begin
            last_rd_exp = exp_mem[ma];
            chk("read_data", 32'(cpu_rdata), 32'(last_rd_exp));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          c0, p0;
        bit          saw;
        bit          wr, t;
        logic [19:0] a;
        logic [7:0]  d;

        for (int i = 0; i < 32768; i++) exp_mem[i] = seed_byte(15'(i));
        reset_l = 1'b0; bus_a = 20'h0; bus_memr_l = 1'b1; bus_memw_l = 1'b1;
        bus_aen = 1'b0; bus_d = 8'h00; tandy_32k = 1'b0;
        disp_req = 1'b0; disp_addr = 19'h0; isa_op_enable = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("reset_rdy", 32'(bus_rdy), 32'd1);
        chk("reset_we", 32'(ram_we_l), 32'd1);
        chk("reset_rdata", 32'(cpu_rdata), 32'h00);
        chk("reset_addr", 32'(ram_a), 32'(disp_addr));
        @(negedge clk);
        reset_l = 1'b1;
        repeat (3) @(negedge clk);

        // Basic write and mirrored / 32K reads.
        win_mode = 1'b1; disp_en = 1'b0;
        cpu_access(1'b1, 20'hB8123, 8'h5A, 1'b0);
        cpu_access(1'b0, 20'hBC123, 8'h00, 1'b0);
        cpu_access(1'b0, 20'hBC123, 8'h00, 1'b1);

        // Decode rejection: DMA cycle, then an address outside the window.
        c0 = completed;
        bus_a = 20'hB8000; bus_aen = 1'b1;
        @(negedge clk); #1; bus_memw_l = 1'b0;
        saw = 1'b0;
        repeat (10) begin @(negedge clk); saw |= (bus_rdy !== 1'b1) || (ram_we_l !== 1'b1); end
        chk("aen_blocks", 32'(saw), 32'd0);
        bus_memw_l = 1'b1; bus_aen = 1'b0;
        repeat (4) @(negedge clk);
        bus_a = 20'hA0000;
        @(negedge clk); #1; bus_memr_l = 1'b0;
        #1 chk("rd_active_nohit", 32'(cpu_rd_active), 32'd0);
        saw = 1'b0;
        repeat (10) begin @(negedge clk); saw |= (bus_rdy !== 1'b1) || (ram_we_l !== 1'b1); end
        chk("a0000_blocks", 32'(saw), 32'd0);
        bus_memr_l = 1'b1;
        repeat (4) @(negedge clk);
        chk("nohit_no_write", 32'(completed), 32'(c0));
        chk("nohit_rdata", 32'(cpu_rdata), 32'(last_rd_exp));

        // Display fetch aborts a write one clock into ACCESS.
        disp_manual = 1'b1; disp_req = 1'b0;
        c0 = completed; p0 = partial;
        bus_a = 20'hB8456; bus_d = 8'h77; tandy_32k = 1'b0;
        @(negedge clk); #1; bus_memw_l = 1'b0;
        wait_we_low(200, n);
        chk("abort_access_seen", 32'(n < 200), 32'd1);
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 19'h12345;
        #1;
        chk("abort_we_high", 32'(ram_we_l), 32'd1);
        chk("abort_addr", 32'(ram_a), 32'h12345);
        repeat (3) @(negedge clk);
        chk("abort_rdy_low", 32'(bus_rdy), 32'd0);
        disp_req = 1'b0; disp_manual = 1'b0;
        wait_level(1'b1, 400, n);
        chk("abort_rdy_rise", 32'(n < 400), 32'd1);
        bus_memw_l = 1'b1;
        repeat (6) @(negedge clk);
        exp_mem[15'h0456] = 8'h77;
        chk("abort_partial", 32'(partial), 32'(p0 + 1));
        chk("abort_one_write", 32'(completed), 32'(c0 + 1));
        chk("abort_write_addr", 32'(last_wa), 32'h00456);
        chk("abort_write_data", 32'(last_wd), 32'h77);

        // Starvation guard with no ISA windows.
        win_mode = 1'b0; disp_manual = 1'b1; disp_req = 1'b0;
        bus_a = 20'hB8700; bus_d = 8'h11;
        @(negedge clk); #1; bus_memw_l = 1'b0;
        wait_level(1'b0, 6, n);
        wait_we_low(100, n);
        chk("starve_forced_after", 32'(n >= MAXW && n <= MAXW + 2), 32'd1);
        wait_level(1'b1, 20, n);
        bus_memw_l = 1'b1;
        repeat (6) @(negedge clk);
        exp_mem[15'h0700] = 8'h11;
        chk("starve_write_addr", 32'(last_wa), 32'h00700);

        // Forced access still waits for display fetch to let go.
        bus_a = 20'hB8701; bus_d = 8'h22;
        @(negedge clk); #1; bus_memw_l = 1'b0;
        wait_level(1'b0, 6, n);
        disp_req = 1'b1;
        saw = 1'b0;
        repeat (60) begin @(negedge clk); saw |= (ram_we_l !== 1'b1); end
        chk("starve_held_by_disp", 32'(saw), 32'd0);
        disp_req = 1'b0;
        wait_we_low(10, n);
        chk("starve_after_disp", 32'(n <= 2), 32'd1);
        wait_level(1'b1, 20, n);
        bus_memw_l = 1'b1;
        repeat (6) @(negedge clk);
        exp_mem[15'h0701] = 8'h22;
        chk("starve2_write_data", 32'(last_wd), 32'h22);

        // Early strobe release plus a read edge while busy (ignored).
        c0 = completed;
        bus_a = 20'hB8800; bus_d = 8'h99;
        @(negedge clk); #1; bus_memw_l = 1'b0;
        wait_level(1'b0, 6, n);
        bus_memw_l = 1'b1;
        repeat (3) @(negedge clk);
        bus_a = 20'hB8900; bus_memr_l = 1'b0;
        repeat (4) @(negedge clk);
        bus_memr_l = 1'b1;
        wait_level(1'b1, 100, n);
        chk("violation_rdy_rise", 32'(n < 100), 32'd1);
        repeat (6) @(negedge clk);
        exp_mem[15'h0800] = 8'h99;
        chk("violation_one_write", 32'(completed), 32'(c0 + 1));
        chk("violation_addr", 32'(last_wa), 32'h00800);
        saw = 1'b0;
        repeat (10) begin @(negedge clk); saw |= (bus_rdy !== 1'b1); end
        chk("busy_edge_ignored", 32'(saw), 32'd0);
        chk("busy_edge_rdata", 32'(cpu_rdata), 32'(last_rd_exp));

        // Simultaneous read and write strobes: write wins.
        win_mode = 1'b1; disp_manual = 1'b0; disp_en = 1'b1;
        c0 = completed;
        bus_a = 20'hB8A00; bus_d = 8'hE7;
        @(negedge clk); #1; bus_memw_l = 1'b0; bus_memr_l = 1'b0;
        wait_level(1'b0, 6, n);
        wait_level(1'b1, 400, n);
        bus_memw_l = 1'b1; bus_memr_l = 1'b1;
        repeat (6) @(negedge clk);
        exp_mem[15'h0A00] = 8'hE7;
        chk("both_write_wins", 32'(completed), 32'(c0 + 1));
        chk("both_write_data", 32'(last_wd), 32'hE7);
        chk("both_no_read", 32'(cpu_rdata), 32'(last_rd_exp));

        // Reset in the middle of an ACCESS write.
        disp_en = 1'b0;
        bus_a = 20'hB9ABC; bus_d = 8'hC3; tandy_32k = 1'b0;
        @(negedge clk); #1; bus_memw_l = 1'b0;
        wait_we_low(200, n);
        chk("rst_access_seen", 32'(n < 200), 32'd1);
        #2 reset_l = 1'b0;
        #1;
        chk("rst_we_async", 32'(ram_we_l), 32'd1);
        chk("rst_rdy_async", 32'(bus_rdy), 32'd1);
        chk("rst_addr_disp", 32'(ram_a), 32'(disp_addr));
        chk("rst_rdata", 32'(cpu_rdata), 32'h00);
        last_rd_exp = 8'h00;
        bus_memw_l = 1'b1;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        repeat (3) @(negedge clk);
        cpu_access(1'b0, 20'hB8123, 8'h00, 1'b0);

        // Randomized traffic with display contention.
        disp_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            wr = 1'($urandom_range(0, 1));
            t  = 1'($urandom_range(0, 1));
            a  = {5'b10111, 15'($urandom)};
            d  = 8'($urandom);
            cpu_access(wr, a, d, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
